usb_rx_packet_parser: RTL

Downstream stage of the USB receive path. It consumes the byte stream produced by the receiver (rxData / rxDataValid / rxIsLastByte / keepPacket, with CRC16 bytes already stripped) and classifies each packet by PID. It extracts token and SOF fields and forwards DATAx payload bytes to the endpoint backend over a valid/ready interface. At the end of every packet it emits one result strobe carrying a status flag.

---
 rtl/usb_rx_packet_parser.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_packet_parser.sv
// USB receive packet parser: classifies packets by PID, extracts token/SOF fields and
// forwards DATAx payload. Optional build macro USB_RX_PARSER_ADDR_FILTER_EN adds deviceAddr filtering.
module usb_rx_packet_parser #(
  parameter int MAX_DATA_LEN = 64,
  parameter int LEN_W        = $clog2(MAX_DATA_LEN + 1)
) (
  input  logic             clk48,
  input  logic             RST_n,
`ifdef USB_RX_PARSER_ADDR_FILTER_EN
  input  logic [6:0]       deviceAddr,
`endif
  input  logic             rxDataValid,
  input  logic [7:0]       rxData,
  input  logic             rxIsLastByte,
  input  logic             keepPacket,
  output logic             rxAcceptNewData,
  output logic             dataOutValid,
  input  logic             dataOutReady,
  output logic [7:0]       dataOut,
  output logic             dataOutLast,
  output logic             pktValid,
  output logic [3:0]       pktPid,
  output logic             pktOk,
  output logic [1:0]       pktErr,
  output logic [6:0]       tokenAddr,
  output logic [3:0]       tokenEndp,
  output logic [10:0]      frameNum,
  output logic [LEN_W-1:0] dataLen
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TOK1   = 3'd1;
  localparam logic [2:0] S_TOK2   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam logic [1:0] CLS_TOKEN = 2'b01;
  localparam logic [1:0] CLS_DATA  = 2'b11;
  localparam logic [3:0] PID_SOF   = 4'b0101;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DROP = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_DATA_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  logic [2:0]       state, stateNext;
  logic [3:0]       pid, pidNext;
  logic [7:0]       b1, b1Next;
  logic [1:0]       err, errNext;
  logic             keep, keepNext;
  logic             isData, isDataNext;
  logic [LEN_W-1:0] lenCnt, lenNext;
  logic             tokFiltered, filtNext;

  logic             take, finishNow, load, sofUpd, tokUpd, addrOk;
  logic             doValidNext, doLastNext;
  logic [7:0]       doDataNext;
  logic             pktValidNext, pktOkNext;
  logic [3:0]       pktPidNext;
  logic [1:0]       pktErrNext;
  logic [6:0]       tokenAddrNext;
  logic [3:0]       tokenEndpNext;
  logic [10:0]      frameNumNext;
  logic [LEN_W-1:0] dataLenNext;

`ifdef USB_RX_PARSER_ADDR_FILTER_EN
  assign addrOk = (b1[6:0] == deviceAddr);
`else
  assign addrOk = 1'b1;
`endif

  // Upstream handshake: stall only while the payload register is full, or in the result cycle
  always_comb begin
    if (state == S_DATA) begin
      rxAcceptNewData = ~dataOutValid | dataOutReady;
    end else if (state == S_FINISH) begin
      rxAcceptNewData = 1'b0;
    end else begin
      rxAcceptNewData = 1'b1;
    end
  end

  assign take = rxDataValid & rxAcceptNewData;

  // Packet FSM next-state and per-packet bookkeeping
  always_comb begin
    stateNext  = state;
    pidNext    = pid;
    b1Next     = b1;
    errNext    = err;
    keepNext   = keep;
    isDataNext = isData;
    lenNext    = lenCnt;
    filtNext   = tokFiltered;
    finishNow  = 1'b0;
    load       = 1'b0;
    sofUpd     = 1'b0;
    tokUpd     = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          pidNext    = rxData[3:0];
          errNext    = ERR_NONE;
          lenNext    = LEN_ZERO;
          isDataNext = (rxData[1:0] == CLS_DATA);
          if (rxIsLastByte) begin
            keepNext  = keepPacket;
            finishNow = 1'b1;
            stateNext = S_FINISH;
            if (rxData[1:0] == CLS_TOKEN) begin
              errNext = ERR_LEN;
            end else if ((rxData[1:0] == CLS_DATA) && tokFiltered) begin
              errNext = ERR_LEN;
            end else begin
              errNext = ERR_NONE;
            end
          end else if (rxData[1:0] == CLS_TOKEN) begin
            stateNext = S_TOK1;
          end else if ((rxData[1:0] == CLS_DATA) && !tokFiltered) begin
            stateNext = S_DATA;
          end else begin
            // handshake/special with trailing bytes, or payload for a filtered token
            stateNext = S_DRAIN;
            errNext   = ERR_LEN;
          end
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_TOK1: begin
        if (take) begin
          b1Next = rxData;
          if (rxIsLastByte) begin
            keepNext  = keepPacket;
            errNext   = ERR_LEN;
            finishNow = 1'b1;
            stateNext = S_FINISH;
          end else begin
            stateNext = S_TOK2;
          end
        end else begin
          stateNext = S_TOK1;
        end
      end
      S_TOK2: begin
        if (take) begin
          if (rxIsLastByte) begin
            keepNext  = keepPacket;
            finishNow = 1'b1;
            stateNext = S_FINISH;
            if (pid == PID_SOF) begin
              sofUpd = 1'b1;
            end else if (addrOk) begin
              tokUpd   = 1'b1;
              filtNext = 1'b0;
            end else begin
              errNext  = ERR_LEN;
              filtNext = 1'b1;
            end
          end else begin
            stateNext = S_DRAIN;
            errNext   = ERR_LEN;
          end
        end else begin
          stateNext = S_TOK2;
        end
      end
      S_DATA: begin
        if (take) begin
          if (lenCnt == MAX_LEN) begin
            errNext = ERR_OVF;
          end else begin
            load    = 1'b1;
            lenNext = lenCnt + LEN_ONE;
          end
          if (rxIsLastByte) begin
            keepNext  = keepPacket;
            stateNext = S_FLUSH;
          end else begin
            stateNext = S_DATA;
          end
        end else begin
          stateNext = S_DATA;
        end
      end
      S_FLUSH: begin
        if (!dataOutValid) begin
          finishNow = 1'b1;
          stateNext = S_FINISH;
        end else begin
          stateNext = S_FLUSH;
        end
      end
      S_DRAIN: begin
        if (take && rxIsLastByte) begin
          keepNext  = keepPacket;
          finishNow = 1'b1;
          stateNext = S_FINISH;
        end else begin
          stateNext = S_DRAIN;
        end
      end
      S_FINISH: begin
        stateNext = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // Result strobe, payload output register and extracted token/SOF fields
  always_comb begin
    if (finishNow) begin
      pktValidNext = 1'b1;
      pktPidNext   = pidNext;
      pktOkNext    = keepNext && (errNext == ERR_NONE);
      pktErrNext   = keepNext ? errNext : ERR_DROP;
      dataLenNext  = isDataNext ? lenNext : dataLen;
    end else begin
      pktValidNext = 1'b0;
      pktPidNext   = pktPid;
      pktOkNext    = pktOk;
      pktErrNext   = pktErr;
      dataLenNext  = dataLen;
    end

    if (load) begin
      doDataNext  = rxData;
      doLastNext  = rxIsLastByte;
      doValidNext = 1'b1;
    end else if (dataOutReady) begin
      doDataNext  = dataOut;
      doLastNext  = 1'b0;
      doValidNext = 1'b0;
    end else begin
      doDataNext  = dataOut;
      doLastNext  = dataOutLast;
      doValidNext = dataOutValid;
    end

    if (tokUpd) begin
      tokenAddrNext = b1[6:0];
      tokenEndpNext = {rxData[2:0], b1[7]};
    end else begin
      tokenAddrNext = tokenAddr;
      tokenEndpNext = tokenEndp;
    end

    if (sofUpd) begin
      frameNumNext = {rxData[2:0], b1};
    end else begin
      frameNumNext = frameNum;
    end
  end

  // State and output registers
  always_ff @(posedge clk48 or negedge RST_n) begin
    if (!RST_n) begin
      state        <= S_IDLE;
      pid          <= 4'd0;
      b1           <= 8'd0;
      err          <= ERR_NONE;
      keep         <= 1'b0;
      isData       <= 1'b0;
      lenCnt       <= LEN_ZERO;
      tokFiltered  <= 1'b0;
      dataOutValid <= 1'b0;
      dataOut      <= 8'd0;
      dataOutLast  <= 1'b0;
      pktValid     <= 1'b0;
      pktPid       <= 4'd0;
      pktOk        <= 1'b0;
      pktErr       <= ERR_NONE;
      tokenAddr    <= 7'd0;
      tokenEndp    <= 4'd0;
      frameNum     <= 11'd0;
      dataLen      <= LEN_ZERO;
    end else begin
      state        <= stateNext;
      pid          <= pidNext;
      b1           <= b1Next;
      err          <= errNext;
      keep         <= keepNext;
      isData       <= isDataNext;
      lenCnt       <= lenNext;
      tokFiltered  <= filtNext;
      dataOutValid <= doValidNext;
      dataOut      <= doDataNext;
      dataOutLast  <= doLastNext;
      pktValid     <= pktValidNext;
      pktPid       <= pktPidNext;
      pktOk        <= pktOkNext;
      pktErr       <= pktErrNext;
      tokenAddr    <= tokenAddrNext;
      tokenEndp    <= tokenEndpNext;
      frameNum     <= frameNumNext;
      dataLen      <= dataLenNext;
    end
  end

endmodule
